// File: rtl/noc_tx_arb.sv
// Two-requester round-robin packet arbiter feeding a byte-wide NOC from-device port.
// Define NOC_TX_ARB_GAP_EN to insert one idle output byte after every packet.
module noc_tx_arb #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r0_valid,
    input  logic       r0_ctl,
    input  logic       r0_last,
    input  logic [7:0] r0_data,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  logic       r1_ctl,
    input  logic       r1_last,
    input  logic [7:0] r1_data,
    output logic       r1_ready,
    output logic       noc_from_dev_ctl,
    output logic [7:0] noc_from_dev_data,
    output logic       arb_busy,
    output logic       arb_grant,
    output logic [7:0] pkt_cnt0,
    output logic [7:0] pkt_cnt1
);

`ifdef NOC_TX_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
    localparam state_t AFTER_PKT = GAP;
`else
    typedef enum logic {IDLE, XFER} state_t;
    localparam state_t AFTER_PKT = IDLE;
`endif

    state_t     state;
    logic       elig0, elig1, win;
    logic       acc, acc_idx, acc_ctl, acc_last;
    logic [7:0] acc_data;

    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        elig0    = r0_valid && r0_ctl;
        elig1    = r1_valid && r1_ctl;
        // On a tie the requester that did not win last time goes first.
        win      = (elig0 && elig1) ? ~arb_grant : elig1;
        if (reset) begin
            case (state)
                IDLE: begin
                    r0_ready = elig0 && !win;
                    r1_ready = elig1 && win;
                end
                XFER: begin
                    r0_ready = r0_valid && !arb_grant;
                    r1_ready = r1_valid && arb_grant;
                end
                default: ;
            endcase
        end
        acc      = r0_ready || r1_ready;
        acc_idx  = r1_ready;
        acc_ctl  = acc_idx ? r1_ctl  : r0_ctl;
        acc_last = acc_idx ? r1_last : r0_last;
        acc_data = acc_idx ? r1_data : r0_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            arb_grant         <= 1'b1;
            pkt_cnt0          <= 8'h00;
            pkt_cnt1          <= 8'h00;
            noc_from_dev_ctl  <= 1'b1;
            noc_from_dev_data <= IDLE_BYTE;
        end else begin
            noc_from_dev_ctl  <= acc ? acc_ctl  : 1'b1;
            noc_from_dev_data <= acc ? acc_data : IDLE_BYTE;
            case (state)
                IDLE: begin
                    if (acc) begin
                        arb_grant <= acc_idx;
                        state     <= acc_last ? AFTER_PKT : XFER;
                    end
                end
                XFER: begin
                    if (acc && acc_last)
                        state <= AFTER_PKT;
                end
                default: state <= IDLE;
            endcase
            if (acc && acc_last) begin
                if (acc_idx)
                    pkt_cnt1 <= pkt_cnt1 + 8'd1;
                else
                    pkt_cnt0 <= pkt_cnt0 + 8'd1;
            end
        end
    end

    assign arb_busy = (state == XFER);

endmodule

// File: tb/tb_noc_tx_arb.sv
// Bench for noc_tx_arb: packet-level reference model checked every cycle, plus directed scenarios.
module tb_noc_tx_arb;
    localparam logic [7:0]  IB   = 8'hE5;
    localparam logic [10:0] NONE = 11'd0;
`ifdef NOC_TX_ARB_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r0_valid = 1'b0, r0_ctl = 1'b0, r0_last = 1'b0;
    logic [7:0] r0_data = 8'h00;
    logic       r1_valid = 1'b0, r1_ctl = 1'b0, r1_last = 1'b0;
    logic [7:0] r1_data = 8'h00;
    logic       r0_ready, r1_ready, noc_from_dev_ctl, arb_busy, arb_grant;
    logic [7:0] noc_from_dev_data, pkt_cnt0, pkt_cnt1;

    int errors = 0;
    int checks = 0;
    logic [10:0] cur0 = NONE, cur1 = NONE;

    noc_tx_arb #(.IDLE_BYTE(IB)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ctl(r0_ctl), .r0_last(r0_last), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_ctl(r1_ctl), .r1_last(r1_last), .r1_data(r1_data), .r1_ready(r1_ready),
        .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
        .arb_busy(arb_busy), .arb_grant(arb_grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: who owns the link, who won last, and what the port should show.
    int         m_owner;
    bit         m_gap, m_lg;
    logic [7:0] m_cnt0, m_cnt1, m_data;
    logic       m_ctl;
    logic [1:0] m_rd;
    logic       m_side, m_bc, m_bl;
    logic [7:0] m_bd;

    always_comb begin
        m_rd = 2'b00;
        if (reset && !m_gap) begin
            if (m_owner < 0) begin
                if (r0_valid && r0_ctl && r1_valid && r1_ctl)
                    m_rd = m_lg ? 2'b01 : 2'b10;
                else if (r0_valid && r0_ctl)
                    m_rd = 2'b01;
                else if (r1_valid && r1_ctl)
                    m_rd = 2'b10;
            end else if (m_owner == 0) begin
                m_rd = {1'b0, r0_valid};
            end else begin
                m_rd = {r1_valid, 1'b0};
            end
        end
    end

    assign m_side = m_rd[1];
    assign m_bc   = m_side ? r1_ctl  : r0_ctl;
    assign m_bl   = m_side ? r1_last : r0_last;
    assign m_bd   = m_side ? r1_data : r0_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= -1; m_gap <= 1'b0; m_lg <= 1'b1;
            m_cnt0 <= 8'h00; m_cnt1 <= 8'h00; m_ctl <= 1'b1; m_data <= IB;
        end else begin
            m_gap <= 1'b0;
            if (m_rd == 2'b00) begin
                m_ctl <= 1'b1; m_data <= IB;
            end else begin
                m_ctl <= m_bc; m_data <= m_bd;
                if (m_owner < 0) m_lg <= m_side;
                if (m_bl) begin
                    m_owner <= -1;
                    m_gap   <= GAP;
                    if (m_side) m_cnt1 <= m_cnt1 + 8'd1;
                    else        m_cnt0 <= m_cnt0 + 8'd1;
                end else begin
                    m_owner <= m_side ? 1 : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        chk("r0_ready", r0_ready, m_rd[0]);
        chk("r1_ready", r1_ready, m_rd[1]);
        chk("out_ctl", noc_from_dev_ctl, m_ctl);
        chk("out_data", noc_from_dev_data, m_data);
        chk("busy", arb_busy, m_owner >= 0);
        chk("grant", arb_grant, m_lg);
        chk("cnt0", pkt_cnt0, m_cnt0);
        chk("cnt1", pkt_cnt1, m_cnt1);
    end

    // Inputs are {valid, ctl, last, data[7:0]}.
    task automatic go(input logic [10:0] a, input logic [10:0] b);
        @(negedge clk);
        cur0 = a; cur1 = b;
        {r0_valid, r0_ctl, r0_last, r0_data} = a;
        {r1_valid, r1_ctl, r1_last, r1_data} = b;
        #3;
    endtask

    task automatic send(input bit side, input logic [10:0] w, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (side) go(cur0, w);
            else      go(w, cur1);
            got = side ? r1_ready : r0_ready;
        end
        chk(nm, got, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cur0 = NONE; cur1 = NONE;
        {r0_valid, r0_ctl, r0_last, r0_data} = NONE;
        {r1_valid, r1_ctl, r1_last, r1_data} = NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        r0_valid = 1'b1; r0_ctl = 1'b1;
        #3;
        chk("rst_ctl", noc_from_dev_ctl, 1);
        chk("rst_data", noc_from_dev_data, IB);
        chk("rst_grant", arb_grant, 1);
        chk("rst_busy", arb_busy, 0);
        chk("rst_r0_ready", r0_ready, 0);
        r0_valid = 1'b0; r0_ctl = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Single three-byte packet from r0
        go({3'b110, 8'h21}, NONE);
        chk("p1_rdy", r0_ready, 1);
        go({3'b100, 8'hAA}, NONE);
        chk("p1_b0", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, 8'h21});
        go({3'b101, 8'h55}, NONE);
        chk("p1_b1", {noc_from_dev_ctl, noc_from_dev_data}, {1'b0, 8'hAA});
        chk("p1_busy", arb_busy, 1);
        go(NONE, NONE);
        chk("p1_b2", {noc_from_dev_ctl, noc_from_dev_data}, {1'b0, 8'h55});
        chk("p1_cnt0", pkt_cnt0, 1);

        // Ties after reset: r0, then r1, then r0
        do_reset();
        go({3'b111, 8'h30}, {3'b111, 8'h31});
        chk("tie1_r0", r0_ready, 1);
        chk("tie1_r1", r1_ready, 0);
        for (int i = 0; i < 4; i++) begin
            go({3'b111, 8'h32}, {3'b111, 8'h31});
            if (r0_ready || r1_ready) break;
        end
        chk("tie2_r1", r1_ready, 1);
        chk("tie2_r0", r0_ready, 0);
        chk("tie2_grant", arb_grant, 0);
        for (int i = 0; i < 4; i++) begin
            go({3'b111, 8'h32}, {3'b111, 8'h33});
            if (r0_ready || r1_ready) break;
        end
        chk("tie3_r0", r0_ready, 1);
        chk("tie3_r1", r1_ready, 0);
        go(NONE, NONE);
        go(NONE, NONE);

        // Mid-packet stall of r0 while r1 waits
        send(0, {3'b110, 8'h40}, "st_b0");
        send(0, {3'b100, 8'h41}, "st_b1");
        go(NONE, {3'b111, 8'h50});
        chk("st_hold1_r1", r1_ready, 0);
        go(NONE, {3'b111, 8'h50});
        chk("st_hold2_r1", r1_ready, 0);
        chk("st_idle1", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, IB});
        go({3'b101, 8'h42}, {3'b111, 8'h50});
        chk("st_idle2", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, IB});
        chk("st_resume_r0", r0_ready, 1);
        chk("st_resume_r1", r1_ready, 0);
        send(1, {3'b111, 8'h50}, "st_r1");
        go(NONE, NONE);
        go(NONE, NONE);

        // 256 single-byte r1 packets wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = i[7:0];
            send(1, {3'b111, d}, "wrap_pkt");
        end
        go(NONE, NONE);
        go(NONE, NONE);
        chk("wrap_cnt1", pkt_cnt1, 0);
        chk("wrap_cnt0", pkt_cnt0, 0);

        // Reset in the middle of a four-byte packet
        do_reset();
        send(0, {3'b110, 8'h60}, "mr_b0");
        send(0, {3'b100, 8'h61}, "mr_b1");
        go({3'b100, 8'h62}, NONE);
        reset = 1'b0;
        #1;
        chk("mr_ctl", noc_from_dev_ctl, 1);
        chk("mr_data", noc_from_dev_data, IB);
        chk("mr_busy", arb_busy, 0);
        chk("mr_r0_ready", r0_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        go({3'b100, 8'h62}, NONE);
        chk("mr_after_b2", r0_ready, 0);
        go({3'b101, 8'h63}, NONE);
        chk("mr_after_b3", r0_ready, 0);
        chk("mr_idle_out", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, IB});
        go(NONE, NONE);
        chk("mr_idle_out2", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, IB});
        send(0, {3'b111, 8'h70}, "mr_new");
        go(NONE, NONE);
        chk("mr_new_out", {noc_from_dev_ctl, noc_from_dev_data}, {1'b1, 8'h70});
        go(NONE, NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
